// File: rtl/reaction_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction timer: controller state encoding,
// counter widths, elapsed-time ceiling, and the 16-bit Fibonacci LFSR
// (seed, tap mask and single-step helper).
// ----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_EXPIRED = 3'd2,
        ST_TIMING  = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int DELAY_W   = 12;
    localparam int ELAPSED_W = 14;

    localparam logic [ELAPSED_W-1:0] MAX_ELAPSED = 14'd9999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 (1-based) map to bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci step: shift left, feedback = XOR of tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// ----------------------------------------------------------------------------
// ms_prescaler
// Free-running 0..TICKS_PER_MS-1 counter producing a one-cycle ms tick on
// the last count, then wrapping to 0.
//
// Ports
//   clk        system clock (rising edge)
//   reset      synchronous active-high reset, count -> 0
//   clr_i      synchronous clear, count -> 0 (restarts the ms phase)
//   ms_tick_o  high for one cycle while count == TICKS_PER_MS-1
// ----------------------------------------------------------------------------
module ms_prescaler #(
    parameter int TICKS_PER_MS = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic ms_tick_o
);

    localparam int CW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_MS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign ms_tick_o = (count_q == LAST);

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr_i || ms_tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// ----------------------------------------------------------------------------
// reaction_timer
// Random pre-LED delay followed by a millisecond reaction-time counter.
// arm loads MIN_DELAY_MS plus RAND_BITS LFSR bits into a ms down-counter;
// when it expires delay_done is raised.  start_timer/stop_timer then run and
// freeze a saturating ms counter (0..9999).
//
// Ports
//   clk           system clock (rising edge)
//   reset         synchronous active-high reset
//   arm           pulse: start a new random delay (any state)
//   abort         pulse: cancel a pending delay (DELAY only)
//   start_timer   pulse: start timing (IDLE, EXPIRED, HOLD)
//   stop_timer    pulse: freeze timing (TIMING only)
//   delay_done    high while the delay has expired and timing has not started
//   elapsed_time  measured reaction time in ms
//   running       high while elapsed_time is counting
//   overflow      high once elapsed_time has saturated at 9999
// ----------------------------------------------------------------------------
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS = 10000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 start_timer,
    input  logic                 stop_timer,
    output logic                 delay_done,
    output logic [ELAPSED_W-1:0] elapsed_time,
    output logic                 running,
    output logic                 overflow
);

    state_t                 state_q,     state_d;
    logic [DELAY_W-1:0]     delay_cnt_q, delay_cnt_d;
    logic [ELAPSED_W-1:0]   elapsed_q,   elapsed_d;
    logic                   overflow_q,  overflow_d;
    logic [15:0]            lfsr_q;
    logic [15:0]            lfsr_step;
    logic                   delay_done_q;
    logic                   running_q;
    logic                   ms_tick;
    logic                   start_accept;
    logic                   presc_clr;

    // Restarting the prescaler on arm/start makes every interval an exact
    // whole number of ms measured from the triggering pulse.
    assign presc_clr = arm | start_accept;

    ms_prescaler #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (presc_clr),
        .ms_tick_o (ms_tick)
    );

    // A zero state would lock the LFSR; fall back to the seed if reached.
    always_comb begin
        lfsr_step = lfsr_next(lfsr_q);
        if (lfsr_step == 16'h0000) begin
            lfsr_step = LFSR_SEED;
        end
    end

    always_comb begin
        state_d      = state_q;
        delay_cnt_d  = delay_cnt_q;
        elapsed_d    = elapsed_q;
        overflow_d   = overflow_q;
        start_accept = 1'b0;

        if (arm) begin
            // arm outranks every other pulse and is honoured in any state.
            state_d     = ST_DELAY;
            delay_cnt_d = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[RAND_BITS-1:0]);
            elapsed_d   = '0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DELAY: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else if (ms_tick) begin
                        if (delay_cnt_q <= DELAY_W'(1)) begin
                            delay_cnt_d = '0;
                            state_d     = ST_EXPIRED;
                        end else begin
                            delay_cnt_d = delay_cnt_q - 1'b1;
                        end
                    end
                end

                ST_TIMING: begin
                    // stop wins over a coincident tick: the partial ms is dropped.
                    if (stop_timer) begin
                        state_d = ST_HOLD;
                    end else if (ms_tick && (elapsed_q != MAX_ELAPSED)) begin
                        elapsed_d = elapsed_q + 1'b1;
                        if (elapsed_q == MAX_ELAPSED - 1'b1) begin
                            overflow_d = 1'b1;
                        end
                    end
                end

                ST_IDLE, ST_EXPIRED, ST_HOLD: begin
                    if (start_timer) begin
                        start_accept = 1'b1;
                        state_d      = ST_TIMING;
                        elapsed_d    = '0;
                        overflow_d   = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            delay_cnt_q  <= '0;
            elapsed_q    <= '0;
            overflow_q   <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            delay_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_cnt_q  <= delay_cnt_d;
            elapsed_q    <= elapsed_d;
            overflow_q   <= overflow_d;
            lfsr_q       <= lfsr_step;
            // Status flags are registered decodes of the current state, so
            // they follow the state by one cycle and are glitch-free.
            delay_done_q <= (state_q == ST_EXPIRED);
            running_q    <= (state_q == ST_TIMING);
        end
    end

    assign delay_done   = delay_done_q;
    assign elapsed_time = elapsed_q;
    assign running      = running_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_reaction_timer.sv
// ----------------------------------------------------------------------------
// tb_reaction_timer
// Self-checking bench for reaction_timer with TICKS_PER_MS=4,
// MIN_DELAY_MS=5, RAND_BITS=1.  Expected values are pushed to a scoreboard
// queue when stimulus is applied and popped when the DUT result is observed.
// ----------------------------------------------------------------------------
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        abort;
    logic        start_timer;
    logic        stop_timer;
    logic        delay_done;
    logic [13:0] elapsed_time;
    logic        running;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_timer #(
        .TICKS_PER_MS (4),
        .MIN_DELAY_MS (5),
        .RAND_BITS    (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .abort        (abort),
        .start_timer  (start_timer),
        .stop_timer   (stop_timer),
        .delay_done   (delay_done),
        .elapsed_time (elapsed_time),
        .running      (running),
        .overflow     (overflow)
    );

    // Reference LFSR: seed 16'hACE1, taps 16,14,13,11, one step per cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic push_exp(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got %0d expected none", obs);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    endtask

    // Called one half-cycle after the edge that sampled arm.  Returns the
    // number of rising edges from that edge until delay_done is seen high,
    // or -1 if it never rises within the budget.
    task automatic wait_done(output int lat);
        lat = -1;
        if (!delay_done) begin
            for (int n = 1; n <= 300; n++) begin
                @(negedge clk);
                if (delay_done) begin
                    lat = n;
                    break;
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int lat;
        int miss;
        int held;
        int prev;
        int wraps;
        int got3;

        reset       = 1'b1;
        arm         = 1'b0;
        abort       = 1'b0;
        start_timer = 1'b0;
        stop_timer  = 1'b0;

        // Reset for two cycles.
        repeat (2) @(negedge clk);
        check_eq("rst_elapsed",    elapsed_time, 0);
        check_eq("rst_delay_done", delay_done,   0);
        check_eq("rst_running",    running,      0);
        check_eq("rst_overflow",   overflow,     0);

        // Arm on the first cycle out of reset: D = 5 + lfsr[0].
        reset = 1'b0;
        arm   = 1'b1;
        d     = 5 + int'(m_lfsr[0]);
        push_exp("arm_latency", 4 * d + 1);
        @(negedge clk);
        arm = 1'b0;
        wait_done(lat);
        pop_check(lat);

        miss = 0;
        repeat (20) begin
            @(negedge clk);
            if (!delay_done) miss++;
        end
        check_eq("done_stays_high", miss, 0);

        // From EXPIRED: start, 40 idle cycles, stop -> 10 ms.
        start_timer = 1'b1;
        @(negedge clk);
        start_timer = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("running_mid", running, 1);
        check_eq("done_low_timing", delay_done, 0);
        repeat (20) @(negedge clk);
        stop_timer = 1'b1;
        @(negedge clk);
        stop_timer = 1'b0;
        push_exp("elapsed_after_stop", 10);
        repeat (2) @(negedge clk);
        pop_check(elapsed_time);
        check_eq("running_after_stop", running, 0);

        held = elapsed_time;
        miss = 0;
        repeat (100) begin
            @(negedge clk);
            if (elapsed_time != 14'(held)) miss++;
        end
        check_eq("hold_100_changes", miss, 0);

        // Saturation run from HOLD.
        start_timer = 1'b1;
        @(negedge clk);
        start_timer = 1'b0;
        prev  = 0;
        wraps = 0;
        for (int i = 1; i <= 40020; i++) begin
            @(negedge clk);
            if (int'(elapsed_time) < prev) wraps++;
            if (int'(elapsed_time) > 9999) wraps++;
            prev = elapsed_time;
            if (i == 401) begin
                check_eq("rate_at_401", elapsed_time, 100);
                check_eq("ovf_low_at_401", overflow, 0);
            end
        end
        push_exp("sat_elapsed", 9999);
        pop_check(elapsed_time);
        check_eq("sat_overflow", overflow, 1);
        check_eq("sat_no_wrap", wraps, 0);
        check_eq("sat_running", running, 1);

        // Arm then abort 8 cycles later: delay_done never rises.
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check_eq("arm_clears_elapsed",  elapsed_time, 0);
        check_eq("arm_clears_overflow", overflow,     0);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        miss = 0;
        repeat (200) begin
            @(negedge clk);
            if (delay_done) miss++;
        end
        check_eq("abort_done_high_cycles", miss, 0);

        // From IDLE: stop coincides with the second ms tick -> only 1 ms.
        start_timer = 1'b1;
        @(negedge clk);
        start_timer = 1'b0;
        repeat (7) @(negedge clk);
        stop_timer = 1'b1;
        @(negedge clk);
        stop_timer = 1'b0;
        push_exp("stop_on_tick", 1);
        @(negedge clk);
        pop_check(elapsed_time);

        // Reset in the middle of timing at elapsed_time = 3.
        start_timer = 1'b1;
        @(negedge clk);
        start_timer = 1'b0;
        got3 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (elapsed_time == 14'd3) begin
                got3 = 1;
                break;
            end
        end
        check_eq("reached_elapsed_3", got3, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_elapsed",    elapsed_time, 0);
        check_eq("midrst_delay_done", delay_done,   0);
        check_eq("midrst_running",    running,      0);
        check_eq("midrst_overflow",   overflow,     0);

        // LFSR reseeded: first arm after reset uses lfsr[0] of 16'hACE1.
        reset = 1'b0;
        arm   = 1'b1;
        d     = 5 + int'(m_lfsr[0]);
        push_exp("rearm_latency", 4 * d + 1);
        @(negedge clk);
        arm = 1'b0;
        wait_done(lat);
        pop_check(lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
